// File: rtl/cw305_pmul_pkg.sv
// Shared definitions for the CW305 point-multiply sequencer and its core:
// default widths and the sequencer state encoding.
package cw305_pmul_pkg;

    localparam int unsigned PK_BITS_DEF = 256;
    localparam int unsigned PWORDS_DEF  = 8;
    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned ADDR_BITS   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SCALAR = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } pmul_state_t;

endpackage

// File: rtl/cw305_pmul_seq.sv
// Sequencer between the CW305 register block and the point-multiply core:
// loads the base point, streams the scalar MSB first, then stores the result.
module cw305_pmul_seq
    import cw305_pmul_pkg::*;
#(
    parameter int unsigned pK_BITS = PK_BITS_DEF,
    parameter int unsigned pWORDS  = PWORDS_DEF
) (
    input  logic                   crypto_clk,
    input  logic                   reset_n,

    input  logic                   I_start,
    output logic                   O_ready,
    output logic                   O_busy,
    output logic                   O_done,

    output logic [ADDR_BITS-1:0]   k_addr,
    input  logic [WORD_BITS-1:0]   I_k_word,
    output logic [ADDR_BITS-1:0]   gx_addr,
    output logic [ADDR_BITS-1:0]   gy_addr,
    input  logic [WORD_BITS-1:0]   I_gx_word,
    input  logic [WORD_BITS-1:0]   I_gy_word,

    output logic [ADDR_BITS-1:0]   rx_addr,
    output logic [ADDR_BITS-1:0]   ry_addr,
    output logic                   rx_wren,
    output logic                   ry_wren,
    output logic [WORD_BITS-1:0]   O_rx_word,
    output logic [WORD_BITS-1:0]   O_ry_word,

    output logic                   op_valid,
    output logic [ADDR_BITS-1:0]   op_idx,
    output logic [WORD_BITS-1:0]   op_x_word,
    output logic [WORD_BITS-1:0]   op_y_word,
    output logic                   bit_valid,
    input  logic                   bit_ready,
    output logic                   bit_val,
    output logic                   bit_last,

    output logic                   core_start,
    input  logic                   res_valid,
    output logic [ADDR_BITS-1:0]   res_idx,
    input  logic [WORD_BITS-1:0]   res_x_word,
    input  logic [WORD_BITS-1:0]   res_y_word
);

    localparam int unsigned IDX_W = $clog2(pWORDS + 1);
    localparam int unsigned CNT_W = $clog2(pK_BITS);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(pWORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pK_BITS - 1);

    pmul_state_t      state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             core_start_q;

    logic [IDX_W-1:0] idx_prev;
    logic [CNT_W-1:0] bit_pos;
    logic             idx_in_range;
    logic             idx_is_last;

    // idx runs 0..pWORDS in both LOAD and STORE: addresses go out while
    // idx < pWORDS, and the one-cycle-late data is consumed for idx-1.
    assign idx_prev     = idx - IDX_W'(1);
    assign idx_in_range = (idx < IDX_LAST);
    assign idx_is_last  = (idx == IDX_LAST);
    assign bit_pos      = CNT_LAST - cnt;

    assign O_busy     = (state != ST_IDLE);
    assign O_ready    = ~O_busy;
    assign core_start = core_start_q;

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            core_start_q <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            cnt          <= cnt_nx;
            core_start_q <= (state == ST_IDLE) && I_start;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;

        O_done    = 1'b0;
        k_addr    = '0;
        gx_addr   = '0;
        gy_addr   = '0;
        rx_addr   = '0;
        ry_addr   = '0;
        rx_wren   = 1'b0;
        ry_wren   = 1'b0;
        O_rx_word = '0;
        O_ry_word = '0;
        op_valid  = 1'b0;
        op_idx    = '0;
        op_x_word = '0;
        op_y_word = '0;
        bit_valid = 1'b0;
        bit_val   = 1'b0;
        bit_last  = 1'b0;
        res_idx   = '0;

        case (state)
            ST_IDLE: begin
                if (I_start) begin
                    state_nx = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (idx_in_range) begin
                    gx_addr = ADDR_BITS'(idx);
                    gy_addr = ADDR_BITS'(idx);
                end
                if (idx != '0) begin
                    op_valid  = 1'b1;
                    op_idx    = ADDR_BITS'(idx_prev);
                    op_x_word = I_gx_word;
                    op_y_word = I_gy_word;
                end
                if (idx_is_last) begin
                    idx_nx   = '0;
                    state_nx = ST_SCALAR;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end

            ST_SCALAR: begin
                bit_valid = 1'b1;
                k_addr    = ADDR_BITS'(bit_pos >> 5);
                bit_val   = I_k_word[bit_pos[4:0]];
                bit_last  = (cnt == CNT_LAST);
                if (bit_ready) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = ST_WAIT;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                if (res_valid) begin
                    state_nx = ST_STORE;
                end
            end

            ST_STORE: begin
                if (idx_in_range) begin
                    res_idx = ADDR_BITS'(idx);
                end
                if (idx != '0) begin
                    rx_wren   = 1'b1;
                    ry_wren   = 1'b1;
                    rx_addr   = ADDR_BITS'(idx_prev);
                    ry_addr   = ADDR_BITS'(idx_prev);
                    O_rx_word = res_x_word;
                    O_ry_word = res_y_word;
                end
                if (idx_is_last) begin
                    idx_nx   = '0;
                    state_nx = ST_DONE;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end

            ST_DONE: begin
                O_done   = 1'b1;
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cw305_pmul_seq.sv
// Bench for cw305_pmul_seq: a timeline model of one operation predicts every
// output each cycle; directed and randomized runs exercise it.
module tb_cw305_pmul_seq;

    localparam int K = 256;
    localparam int W = 8;
    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_SCALAR = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_STORE  = 4;
    localparam int PH_DONE   = 5;
    localparam int RUN_LIMIT = 4000;

    logic        crypto_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        I_start    = 1'b0;
    logic        bit_ready  = 1'b0;
    logic        res_valid  = 1'b0;
    logic        O_ready, O_busy, O_done;
    logic [2:0]  k_addr, gx_addr, gy_addr, rx_addr, ry_addr, op_idx, res_idx;
    logic [31:0] I_k_word, I_gx_word, I_gy_word, res_x_word, res_y_word;
    logic [31:0] O_rx_word, O_ry_word, op_x_word, op_y_word;
    logic        rx_wren, ry_wren, op_valid, bit_valid, bit_val, bit_last, core_start;

    logic [K-1:0] k_vec;
    logic [31:0]  k_mem [W];
    logic [31:0]  gx_mem [W];
    logic [31:0]  gy_mem [W];
    logic [31:0]  rsx_mem [W];
    logic [31:0]  rsy_mem [W];
    logic [31:0]  rx_got [W];
    logic [31:0]  ry_got [W];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Operation model: cycle count since start plus handshake count.
    bit m_busy = 1'b0;
    int m_cyc = 0;
    int m_hs = 0;
    int m_store_begin = -1;

    int hs_seen, ones, first_val, op_seen, wr_seen, done_seen, done_cyc, start_cyc;

    cw305_pmul_seq #(.pK_BITS(K), .pWORDS(W)) dut (
        .crypto_clk (crypto_clk),
        .reset_n    (reset_n),
        .I_start    (I_start),
        .O_ready    (O_ready),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .k_addr     (k_addr),
        .I_k_word   (I_k_word),
        .gx_addr    (gx_addr),
        .gy_addr    (gy_addr),
        .I_gx_word  (I_gx_word),
        .I_gy_word  (I_gy_word),
        .rx_addr    (rx_addr),
        .ry_addr    (ry_addr),
        .rx_wren    (rx_wren),
        .ry_wren    (ry_wren),
        .O_rx_word  (O_rx_word),
        .O_ry_word  (O_ry_word),
        .op_valid   (op_valid),
        .op_idx     (op_idx),
        .op_x_word  (op_x_word),
        .op_y_word  (op_y_word),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_val    (bit_val),
        .bit_last   (bit_last),
        .core_start (core_start),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_x_word (res_x_word),
        .res_y_word (res_y_word)
    );

    always #5 crypto_clk = ~crypto_clk;

    assign I_k_word = k_mem[k_addr];

    always @(posedge crypto_clk) begin
        I_gx_word  <= gx_mem[gx_addr];
        I_gy_word  <= gy_mem[gy_addr];
        res_x_word <= rsx_mem[res_idx];
        res_y_word <= rsy_mem[res_idx];
    end

    always @(posedge crypto_clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int phase_of();
        if (!m_busy) return PH_IDLE;
        if (m_cyc <= W + 1) return PH_LOAD;
        if (m_hs < K) return PH_SCALAR;
        if (m_store_begin < 0) return PH_WAIT;
        if (m_cyc < m_store_begin + W + 1) return PH_STORE;
        return PH_DONE;
    endfunction

    always @(posedge crypto_clk or negedge reset_n) begin
        int ph;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            m_hs   = 0;
            m_store_begin = -1;
        end else if (!m_busy) begin
            if (I_start) begin
                m_busy = 1'b1;
                m_cyc  = 1;
                m_hs   = 0;
                m_store_begin = -1;
            end
        end else begin
            ph = phase_of();
            if (ph == PH_SCALAR && bit_ready) m_hs = m_hs + 1;
            if (ph == PH_WAIT && res_valid) m_store_begin = m_cyc + 1;
            if (ph == PH_DONE) m_busy = 1'b0;
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge crypto_clk) begin
        int ph, s, j;
        ph = phase_of();
        chk("ready", O_ready, ph == PH_IDLE);
        chk("busy", O_busy, ph != PH_IDLE);
        chk("done", O_done, ph == PH_DONE);
        chk("core_start", core_start, m_busy && m_cyc == 1);

        chk("op_valid", op_valid, ph == PH_LOAD && m_cyc >= 2);
        if (ph == PH_LOAD && m_cyc <= W) begin
            chk("gx_addr", gx_addr, m_cyc - 1);
            chk("gy_addr", gy_addr, m_cyc - 1);
        end
        if (ph == PH_LOAD && m_cyc >= 2) begin
            chk("op_idx", op_idx, m_cyc - 2);
            chk("op_x_word", op_x_word, gx_mem[m_cyc-2]);
            chk("op_y_word", op_y_word, gy_mem[m_cyc-2]);
        end

        chk("bit_valid", bit_valid, ph == PH_SCALAR);
        if (ph == PH_SCALAR) begin
            j = K - 1 - m_hs;
            chk("bit_val", bit_val, k_vec[j]);
            chk("bit_last", bit_last, m_hs == K - 1);
            chk("k_addr", k_addr, j / 32);
        end else begin
            chk("bit_val_idle", bit_val, 0);
            chk("bit_last_idle", bit_last, 0);
        end

        s = m_cyc - m_store_begin;
        chk("rx_wren", rx_wren, ph == PH_STORE && s >= 1);
        chk("ry_wren", ry_wren, ph == PH_STORE && s >= 1);
        if (ph == PH_STORE && s < W) chk("res_idx", res_idx, s);
        if (ph == PH_STORE && s >= 1) begin
            chk("rx_addr", rx_addr, s - 1);
            chk("ry_addr", ry_addr, s - 1);
            chk("rx_word", O_rx_word, rsx_mem[s-1]);
            chk("ry_word", O_ry_word, rsy_mem[s-1]);
        end

        if (bit_valid && bit_ready) begin
            hs_seen = hs_seen + 1;
            if (bit_val) ones = ones + 1;
            if (hs_seen == 1) first_val = int'(bit_val);
        end
        if (op_valid) op_seen = op_seen + 1;
        if (rx_wren) begin
            wr_seen = wr_seen + 1;
            rx_got[rx_addr] = O_rx_word;
        end
        if (ry_wren) ry_got[ry_addr] = O_ry_word;
        if (O_done) begin
            done_seen = done_seen + 1;
            done_cyc  = cyc;
        end
    end

    task automatic set_k(input logic [K-1:0] v);
        k_vec = v;
        for (int w = 0; w < W; w++) k_mem[w] = v[32*w +: 32];
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < W; i++) begin
            gx_mem[i]  = 32'h1000_0000 + i;
            gy_mem[i]  = 32'h2000_0000 + i;
            rsx_mem[i] = 32'hA0 + i;
            rsy_mem[i] = 32'hB0 + i;
        end
    endtask

    task automatic fill_random();
        logic [K-1:0] v;
        for (int i = 0; i < W; i++) begin
            gx_mem[i]  = $urandom;
            gy_mem[i]  = $urandom;
            rsx_mem[i] = $urandom;
            rsy_mem[i] = $urandom;
            v[32*i +: 32] = $urandom;
        end
        set_k(v);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_op(input int rdy_mode, input int rv_delay, input bit abuse, input int abort_hs);
        int guard, wait_cnt, pcnt, ph;
        hs_seen = 0; ones = 0; first_val = -1; op_seen = 0; wr_seen = 0;
        done_seen = 0; done_cyc = 0;
        for (int i = 0; i < W; i++) begin
            rx_got[i] = '0;
            ry_got[i] = '0;
        end
        @(posedge crypto_clk); #1;
        I_start = 1'b1;
        start_cyc = cyc;
        @(posedge crypto_clk); #1;
        I_start = 1'b0;
        guard = 0; wait_cnt = 0; pcnt = 0;
        while (m_busy && guard < RUN_LIMIT) begin
            ph = phase_of();
            case (rdy_mode)
                0: bit_ready = 1'b1;
                1: bit_ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
                default: bit_ready = 1'($urandom_range(0, 1));
            endcase
            pcnt = pcnt + 1;
            if (ph == PH_WAIT) begin
                res_valid = (wait_cnt >= rv_delay);
                wait_cnt = wait_cnt + 1;
            end else begin
                res_valid = abuse ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            I_start = abuse && ph == PH_SCALAR && ($urandom_range(0, 3) == 0);
            if (abort_hs >= 0 && ph == PH_SCALAR && m_hs == abort_hs) begin
                reset_n = 1'b0;
                #1;
                chk("ready_on_reset", O_ready, 1);
                chk("busy_on_reset", O_busy, 0);
                chk("bit_valid_on_reset", bit_valid, 0);
                break;
            end
            @(posedge crypto_clk); #1;
            guard = guard + 1;
        end
        chk("run_within_budget", guard < RUN_LIMIT, 1);
        I_start = 1'b0;
        res_valid = 1'b0;
        bit_ready = 1'b0;
        if (!reset_n) begin
            repeat (2) @(posedge crypto_clk);
            #1 reset_n = 1'b1;
        end
        repeat (3) @(posedge crypto_clk);
        #1;
    endtask

    task automatic check_full_run();
        chk("done_count", done_seen, 1);
        chk("hs_count", hs_seen, K);
        chk("op_count", op_seen, W);
        chk("wr_count", wr_seen, W);
        for (int i = 0; i < W; i++) begin
            chk("rx_stored", rx_got[i], rsx_mem[i]);
            chk("ry_stored", ry_got[i], rsy_mem[i]);
        end
    endtask

    initial begin
        logic [K-1:0] kv;
        fill_pattern();
        set_k('0);
        repeat (3) @(posedge crypto_clk);
        #1;
        chk("reset_ready", O_ready, 1);
        chk("reset_busy", O_busy, 0);
        chk("reset_core_start", core_start, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge crypto_clk);
        #1;

        // k = 1, immediate result, fixed patterns
        kv = '0;
        kv[0] = 1'b1;
        set_k(kv);
        run_op(0, 0, 1'b0, -1);
        check_full_run();
        chk("basic_done_latency", done_cyc - start_cyc, 276);
        chk("basic_ones", ones, 1);
        chk("basic_rx3", rx_got[3], 32'hA3);
        chk("basic_ry7", ry_got[7], 32'hB7);

        // backpressure with only the MSB set
        kv = '0;
        kv[K-1] = 1'b1;
        set_k(kv);
        run_op(1, 2, 1'b0, -1);
        check_full_run();
        chk("bp_ones", ones, 1);
        chk("bp_first_bit", first_val, 1);

        // spurious I_start and res_valid
        fill_random();
        run_op(2, 3, 1'b1, -1);
        check_full_run();

        // reset during SCALAR at cnt=100, then a fresh run
        fill_random();
        run_op(0, 0, 1'b0, 100);
        chk("abort_done", done_seen, 0);
        chk("abort_writes", wr_seen, 0);
        chk("abort_hs", hs_seen, 100);
        run_op(0, 1, 1'b0, -1);
        check_full_run();

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_op(2, $urandom_range(0, 5), r[0], -1);
            check_full_run();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
